cpu_step_ctrl: RTL and testbench

Clock-enable controller for the CPU core, sitting directly downstream of the free-running clock divider. It consumes the 32-bit divider count and produces a single-cycle `cpu_ce` strobe in the `clk` domain. This replaces a derived CPU clock with an enable. It supports fast or slow free-run, debounced single-step from a push button, and a halt input from the CPU, and it counts executed CPU cycles for the display.

---
 rtl/cpu_step_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the free-running divider count into a one-clk-wide CPU
// clock enable, with fast/slow free-run, debounced single-step and halt.
// Ports: clk/rst (async, active-high); clkdiv divider count; sw_slow picks the
//   slow divider bit; mode_step selects single-step; btn_step raw push button;
//   halt CPU halt level; cpu_ce enable strobe; cycle_cnt pulses issued;
//   state FSM state (RUN=0, STEP_WAIT=1, STEP_FIRE=2, HALTED=3); btn_db
//   debounced button level.
module cpu_step_ctrl #(
  parameter int FAST_BIT   = 2,
  parameter int SLOW_BIT   = 24,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        sw_slow,
  input  logic        mode_step,
  input  logic        btn_step,
  input  logic        halt,
  output logic        cpu_ce,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  state,
  output logic        btn_db
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] STEP_WAIT = 2'd1;
  localparam logic [1:0] STEP_FIRE = 2'd2;
  localparam logic [1:0] HALTED    = 2'd3;

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Only two divider bits matter; the rest are folded here to keep lint quiet.
  logic div_unused;
  assign div_unused = ^clkdiv;

  // Two-flop synchronizer for the asynchronous button.
  logic btn_m;
  logic btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn_step;
      btn_s <= btn_m;
    end
  end

  // Debounce: the accepted level only follows btn_s once it has differed for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      btn_db  <= 1'b0;
    end else if (btn_s == btn_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_db  <= ~btn_db;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  logic btn_db_q;
  logic btn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_db_q <= 1'b0;
    else     btn_db_q <= btn_db;
  end

  assign btn_rise = btn_db & ~btn_db_q;

  // Both divider bits are tracked continuously, so flipping sw_slow only
  // changes which edge detector is looked at and cannot fabricate an edge.
  logic fast_prev;
  logic slow_prev;
  logic fast_rise;
  logic slow_rise;
  logic tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fast_prev <= 1'b0;
      slow_prev <= 1'b0;
    end else begin
      fast_prev <= clkdiv[FAST_BIT];
      slow_prev <= clkdiv[SLOW_BIT];
    end
  end

  assign fast_rise = clkdiv[FAST_BIT] & ~fast_prev;
  assign slow_rise = clkdiv[SLOW_BIT] & ~slow_prev;
  assign tick      = sw_slow ? slow_rise : fast_rise;

  // FSM; halt wins over everything outside HALTED and suppresses the pulse.
  logic [1:0] state_nxt;
  logic       fire;

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          state_nxt = HALTED;
        end else begin
          fire = tick;
          if (mode_step) state_nxt = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (halt)            state_nxt = HALTED;
        else if (!mode_step) state_nxt = RUN;
        else if (btn_rise)   state_nxt = STEP_FIRE;
      end
      STEP_FIRE: begin
        if (halt) begin
          state_nxt = HALTED;
        end else begin
          // Leaving step mode still honours a tick arriving the same cycle.
          fire = tick;
          if (!mode_step) state_nxt = RUN;
          else if (tick)  state_nxt = STEP_WAIT;
        end
      end
      HALTED: begin
        if (!halt) state_nxt = STEP_WAIT;
      end
      default: state_nxt = STEP_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STEP_WAIT;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cpu_ce    <= fire;
      cycle_cnt <= cycle_cnt + {31'd0, fire};
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: drives clkdiv directly, predicts pulse times into a
// queue and checks them as cpu_ce appears; FSM corners via a vector table.
module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] clkdiv;
  logic        sw_slow;
  logic        mode_step;
  logic        btn_step;
  logic        halt;
  logic        cpu_ce;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;
  logic        btn_db;

  cpu_step_ctrl #(
    .FAST_BIT  (2),
    .SLOW_BIT  (24),
    .DEB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clkdiv   (clkdiv),
    .sw_slow  (sw_slow),
    .mode_step(mode_step),
    .btn_step (btn_step),
    .halt     (halt),
    .cpu_ce   (cpu_ce),
    .cycle_cnt(cycle_cnt),
    .state    (state),
    .btn_db   (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int pulses = 0;
  int db_rises = 0;
  logic db_prev = 1'b0;
  int last_ce = -1;
  bit gap_chk = 0;
  bit sb_en   = 1;
  bit permit  = 0;
  bit div_run = 0;
  int exp_q[$];

  typedef struct packed {
    logic [31:0] div;
    logic        m;
    logic        h;
    logic [1:0]  st;
    logic        ce;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply a new divider value; when a pulse is permitted and the selected bit
  // rises, the pulse must appear at the next sample.
  task automatic drive_div(input logic [31:0] nd);
    logic [31:0] od;
    logic fr, sr;
    od = clkdiv;
    clkdiv = nd;
    fr = nd[2] & ~od[2];
    sr = nd[24] & ~od[24];
    if (permit && (sw_slow ? sr : fr)) exp_q.push_back(cyc_n + 1);
  endtask

  task automatic cyc();
    if (div_run) drive_div(clkdiv + 32'd1);
    @(posedge clk);
    #1;
    cyc_n++;
    if (cpu_ce) begin
      pulses++;
      if (gap_chk && last_ce >= 0) chk("ce_period", cyc_n - last_ce, 8);
      last_ce = cyc_n;
    end
    if (sb_en) begin
      if (cpu_ce) begin
        if (exp_q.size() != 0 && exp_q[0] == cyc_n) begin
          chk("ce_time", cyc_n, exp_q.pop_front());
        end else begin
          checks++; errors++;
          $display("FAIL ce_unexpected: pulse at cycle %0d, none required", cyc_n);
        end
      end else if (exp_q.size() != 0 && exp_q[0] <= cyc_n) begin
        checks++; errors++;
        $display("FAIL ce_missing: no pulse at cycle %0d, pulse required", exp_q.pop_front());
      end
    end
    if (btn_db && !db_prev) db_rises++;
    db_prev = btn_db;
  endtask

  task automatic setdiv(input logic [31:0] v);
    drive_div(v);
    cyc();
  endtask

  task automatic settle();
    int n;
    btn_step = 1'b0;
    n = 0;
    while (btn_db && n < 50) begin cyc(); n++; end
  endtask

  task automatic press();
    int n;
    settle();
    btn_step = 1'b1;
    n = 0;
    while (state != 2'd2 && n < 50) begin cyc(); n++; end
    chk("press_fire", {30'd0, state}, 2);
    btn_step = 1'b0;
  endtask

  initial begin
    int p0, r0;
    logic [31:0] c0;

    tbl[0]  = '{32'd0, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[1]  = '{32'd4, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{32'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{32'd4, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[4]  = '{32'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{32'd4, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[6]  = '{32'd0, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[7]  = '{32'd4, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{32'd0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{32'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{32'd4, 1'b0, 1'b0, 2'd0, 1'b1};

    rst = 1'b1; clkdiv = '0; sw_slow = 1'b0; mode_step = 1'b0;
    btn_step = 1'b0; halt = 1'b0;
    repeat (3) cyc();
    chk("rst_ce", {31'd0, cpu_ce}, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_state", {30'd0, state}, 1);
    chk("rst_db", {31'd0, btn_db}, 0);

    // Fast free-run.
    rst = 1'b0; div_run = 1; permit = 1; gap_chk = 1;
    cyc();
    chk("run_entry", {30'd0, state}, 0);
    for (int i = 0; i < 200 && pulses < 10; i++) cyc();
    chk("ten_pulses", pulses, 10);
    chk("cnt_after_10", cycle_cnt, 10);
    gap_chk = 0; div_run = 0;

    // Slow switch while both divider bits are high.
    p0 = pulses;
    setdiv(32'h0000_0000);
    setdiv(32'h0100_0004);
    cyc();
    sw_slow = 1'b1;
    repeat (4) cyc();
    setdiv(32'h0100_0000);
    setdiv(32'h0100_0004);
    setdiv(32'h0000_0000);
    setdiv(32'h0100_0000);
    cyc();
    sw_slow = 1'b0;
    setdiv(32'h0100_0004);
    cyc();
    chk("slow_pulses", pulses - p0, 3);
    chk("slow_state", {30'd0, state}, 0);

    // Counter wrap.
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    setdiv(32'h0000_0000);
    chk("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
    setdiv(32'h0000_0004);
    chk("wrap_zero", cycle_cnt, 0);

    // Halt from RUN, then resume into step mode.
    p0 = pulses;
    halt = 1'b1; permit = 0; div_run = 1;
    cyc();
    chk("halt_state", {30'd0, state}, 3);
    repeat (20) cyc();
    chk("halt_no_pulse", pulses - p0, 0);
    mode_step = 1'b1; halt = 1'b0; div_run = 0;
    cyc();
    chk("unhalt_state", {30'd0, state}, 1);
    setdiv(32'd0);
    press();
    permit = 1;
    setdiv(32'd4);
    permit = 0;
    chk("step_back_wait", {30'd0, state}, 1);
    setdiv(32'd0);
    setdiv(32'd4);
    chk("step_one_pulse", pulses - p0, 1);

    // Bouncing press: one debounced rise, one pulse.
    settle();
    chk("bounce_db_idle", {31'd0, btn_db}, 0);
    setdiv(32'd0);
    p0 = pulses; r0 = db_rises;
    for (int i = 0; i < 12; i++) begin
      btn_step = (i % 4) >= 2;
      cyc();
    end
    chk("bounce_no_db", db_rises - r0, 0);
    btn_step = 1'b1;
    repeat (10) cyc();
    chk("bounce_one_rise", db_rises - r0, 1);
    chk("bounce_fire", {30'd0, state}, 2);
    permit = 1;
    setdiv(32'd4);
    permit = 0;
    setdiv(32'd0);
    setdiv(32'd4);
    chk("bounce_one_pulse", pulses - p0, 1);
    chk("bounce_wait", {30'd0, state}, 1);

    // Short glitch is rejected.
    settle();
    r0 = db_rises;
    btn_step = 1'b1;
    repeat (3) cyc();
    btn_step = 1'b0;
    repeat (10) cyc();
    chk("glitch_rise", db_rises - r0, 0);
    chk("glitch_db", {31'd0, btn_db}, 0);
    chk("glitch_state", {30'd0, state}, 1);

    // Vector table for FSM transitions against ticks.
    sb_en = 0;
    c0 = cycle_cnt;
    for (int i = 0; i < 11; i++) begin
      mode_step = tbl[i].m;
      halt      = tbl[i].h;
      drive_div(tbl[i].div);
      cyc();
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
      chk($sformatf("vec%0d_ce", i), {31'd0, cpu_ce}, {31'd0, tbl[i].ce});
    end
    chk("vec_cnt", cycle_cnt, c0 + 32'd2);
    sb_en = 1;

    // STEP_FIRE left for RUN with a tick in the same cycle.
    mode_step = 1'b1;
    setdiv(32'd0);
    press();
    p0 = pulses;
    mode_step = 1'b0; permit = 1;
    setdiv(32'd4);
    permit = 0;
    chk("fire_to_run", {30'd0, state}, 0);
    chk("fire_to_run_pulse", pulses - p0, 1);

    // Halt in STEP_FIRE with a tick: no pulse.
    mode_step = 1'b1;
    setdiv(32'd0);
    press();
    p0 = pulses;
    halt = 1'b1;
    setdiv(32'd4);
    chk("fire_halt_state", {30'd0, state}, 3);
    halt = 1'b0;
    cyc();
    chk("fire_halt_pulse", pulses - p0, 0);
    chk("fire_unhalt", {30'd0, state}, 1);

    // Reset while a step is pending.
    setdiv(32'd0);
    press();
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_ce", {31'd0, cpu_ce}, 0);
    chk("rstmid_state", {30'd0, state}, 1);
    chk("rstmid_cnt", cycle_cnt, 0);
    cyc();
    cyc();
    rst = 1'b0;
    p0 = pulses;
    setdiv(32'd4);
    setdiv(32'd0);
    setdiv(32'd4);
    repeat (10) cyc();
    chk("rstmid_no_pulse", pulses - p0, 0);
    chk("rstmid_after", {30'd0, state}, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
